// File: rtl/usf_diff_fold_n_if.sv
// Sample-in / residual-out handshake bundle for usf_diff_fold_n.
// master = upstream driver side, slave = the folding block.
interface usf_diff_fold_n_if #(
    parameter int WIDTH = 24
);
    logic                    clk_en;
    logic                    valid_in;
    logic signed [WIDTH-1:0] sample_in;
    logic                    in_ready;
    logic                    valid_out;
    logic signed [WIDTH-1:0] residual_diff_out;
    logic                    fold_err;

    modport master (
        output clk_en, valid_in, sample_in,
        input  in_ready, valid_out, residual_diff_out, fold_err
    );

    modport slave (
        input  clk_en, valid_in, sample_in,
        output in_ready, valid_out, residual_diff_out, fold_err
    );
endinterface

// File: rtl/usf_diff_fold_n.sv
// N-th order difference of folded samples, iteratively re-folded into [-lambda, lambda);
// emits the accumulated 2*lambda correction as the residual difference.
module usf_diff_fold_n #(
    parameter int  WIDTH           = 24,
    parameter int  FRACTIONAL_BITS = 16,
    parameter int  ORDER           = 2,
    parameter real LAMBDA          = 0.75,
    parameter int  MAX_FOLD        = 15
) (
    input  logic              clk,
    input  logic              reset,
    usf_diff_fold_n_if.slave  bus
);
    localparam int DW = WIDTH + ORDER;
    localparam int CW = WIDTH + ORDER + 1;
    localparam int PW = $clog2(ORDER + 1);
    localparam int NW = $clog2(MAX_FOLD + 1);
    localparam int LAMBDA_Q = int'(LAMBDA * real'(longint'(1) << FRACTIONAL_BITS));
    localparam logic signed [CW-1:0] LQ      = CW'(LAMBDA_Q);
    localparam logic signed [CW-1:0] TLQ     = CW'(2 * LAMBDA_Q);
    localparam logic signed [CW-1:0] SAT_MAX = CW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_MIN = -SAT_MAX - CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_FOLD, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] hist_q [ORDER];
    logic signed [WIDTH-1:0] hist_d [ORDER];
    logic [PW-1:0]           prime_q, prime_d;
    logic [NW-1:0]           n_q, n_d;
    logic signed [CW-1:0]    d_q, d_d;
    logic signed [CW-1:0]    corr_q, corr_d;
    logic                    valid_out_q, valid_out_d;
    logic signed [WIDTH-1:0] resid_q, resid_d;
    logic                    fold_err_q, fold_err_d;

    logic signed [DW-1:0]    casc [ORDER+1];
    logic signed [DW-1:0]    delta;
    logic                    in_ready;
    logic                    accept;
    logic                    need_dn;
    logic                    need_up;

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [CW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        else                  return v[WIDTH-1:0];
    endfunction

    // In-place difference cascade: after ORDER passes casc[0] holds the N-th difference.
    always_comb begin
        casc[0] = DW'(bus.sample_in);
        for (int unsigned i = 1; i <= ORDER; i++) casc[i] = DW'(hist_q[i-1]);
        for (int unsigned s = 0; s < ORDER; s++)
            for (int unsigned j = 0; j < ORDER - s; j++)
                casc[j] = casc[j] - casc[j+1];
        delta = casc[0];
    end

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        prime_d     = prime_q;
        n_d         = n_q;
        d_d         = d_q;
        corr_d      = corr_q;
        valid_out_d = valid_out_q;
        resid_d     = resid_q;
        fold_err_d  = fold_err_q;

        in_ready = bus.clk_en & ~reset & (state_q == S_IDLE || state_q == S_OUT);
        accept   = bus.valid_in & in_ready;
        need_dn  = (d_q >= LQ);
        need_up  = (d_q < -LQ);

        if (bus.clk_en) begin
            valid_out_d = 1'b0;
            case (state_q)
                S_IDLE, S_OUT: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        hist_d[0] = bus.sample_in;
                        for (int unsigned i = 1; i < ORDER; i++) hist_d[i] = hist_q[i-1];
                        if (prime_q == PW'(ORDER)) begin
                            d_d     = CW'(delta);
                            corr_d  = '0;
                            n_d     = '0;
                            state_d = S_FOLD;
                        end else begin
                            prime_d = prime_q + PW'(1);
                        end
                    end
                end
                S_FOLD: begin
                    if ((need_dn || need_up) && n_q != NW'(MAX_FOLD)) begin
                        d_d    = need_dn ? d_q - TLQ : d_q + TLQ;
                        corr_d = need_dn ? corr_q - TLQ : corr_q + TLQ;
                        n_d    = n_q + NW'(1);
                    end else begin
                        // Either in range, or out of fold budget: emit current correction.
                        if (need_dn || need_up) fold_err_d = 1'b1;
                        state_d     = S_OUT;
                        valid_out_d = 1'b1;
                        resid_d     = sat_w(corr_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int unsigned i = 0; i < ORDER; i++) hist_q[i] <= '0;
            prime_q     <= '0;
            n_q         <= '0;
            d_q         <= '0;
            corr_q      <= '0;
            valid_out_q <= 1'b0;
            resid_q     <= '0;
            fold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            prime_q     <= prime_d;
            n_q         <= n_d;
            d_q         <= d_d;
            corr_q      <= corr_d;
            valid_out_q <= valid_out_d;
            resid_q     <= resid_d;
            fold_err_q  <= fold_err_d;
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.valid_out         = valid_out_q;
    assign bus.residual_diff_out = resid_q;
    assign bus.fold_err          = fold_err_q;
endmodule

// File: tb/tb_usf_diff_fold_n.sv
// Randomized + directed bench for usf_diff_fold_n against a closed-form modulo reference
// with a per-sample enabled-cycle latency countdown.
module tb_usf_diff_fold_n;
    localparam int     WIDTH    = 24;
    localparam int     ORDER    = 2;
    localparam int     MAXF     = 4;
    localparam longint LQ       = 49152;
    localparam longint TLQ      = 98304;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usf_diff_fold_n_if #(.WIDTH(WIDTH)) bus ();

    usf_diff_fold_n #(
        .WIDTH(WIDTH), .FRACTIONAL_BITS(16), .ORDER(ORDER), .LAMBDA(0.75), .MAX_FOLD(MAXF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int     checks = 0;
    int     errors = 0;
    longint hist[$];
    bit     pending;
    int     rem;
    longint exp_resid;
    bit     exp_err_pend;
    bit     err_flag;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Binomial form of the N-th backward difference over the accepted-sample history.
    function automatic longint ref_delta(input longint s);
        longint acc = s;
        longint c   = 1;
        for (int k = 1; k <= ORDER; k++) begin
            c   = c * (ORDER - k + 1) / k;
            acc += ((k % 2) ? -c : c) * hist[hist.size() - k];
        end
        return acc;
    endfunction

    // M(x) = ((x + lambda) mod 2lambda) - lambda; residual = M(x) - x, capped at MAXF steps.
    task automatic ref_fold(input longint x, output longint corr, output int n, output bit err);
        longint r = (x + LQ) % TLQ;
        longint lim = (longint'(1) << (WIDTH - 1));
        if (r < 0) r += TLQ;
        corr = (r - LQ) - x;
        n    = int'((corr < 0 ? -corr : corr) / TLQ);
        err  = (n > MAXF);
        if (err) begin
            n    = MAXF;
            corr = (corr < 0 ? -1 : 1) * MAXF * TLQ;
        end
        if (corr > lim - 1) corr = lim - 1;
        if (corr < -lim)    corr = -lim;
    endtask

    task automatic step(input bit en, input bit vin, input longint s, output bit acc);
        bit     out_now, exp_ready;
        longint c;
        int     n;
        bit     e;
        @(negedge clk);
        bus.clk_en    = en;
        bus.valid_in  = vin;
        bus.sample_in = WIDTH'(s);
        if (en && pending) rem--;
        out_now   = en && pending && rem == 0;
        exp_ready = en && (!pending || out_now);
        #1;
        check("in_ready", bus.in_ready, exp_ready);
        if (en) begin
            if (out_now) begin
                pending = 1'b0;
                if (exp_err_pend) err_flag = 1'b1;
                check("valid_out", bus.valid_out, 1);
                check("residual", longint'($signed(bus.residual_diff_out)), exp_resid);
            end else begin
                check("valid_out", bus.valid_out, 0);
            end
            check("fold_err", bus.fold_err, err_flag);
        end
        acc = exp_ready && vin;
        if (acc) begin
            if (hist.size() >= ORDER) begin
                ref_fold(ref_delta(s), c, n, e);
                pending      = 1'b1;
                rem          = 2 + n;
                exp_resid    = c;
                exp_err_pend = e;
            end
            hist.push_back(s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.clk_en = 1'b0; bus.valid_in = 1'b0;
        @(negedge clk);
        bus.clk_en = 1'b1;
        #1;
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_fold_err", bus.fold_err, 0);
        @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_residual", longint'($signed(bus.residual_diff_out)), 0);
        reset = 1'b0;
        hist.delete();
        pending  = 1'b0;
        err_flag = 1'b0;
    endtask

    task automatic feed(input longint s);
        bit a = 1'b0;
        for (int t = 0; t < 40 && !a; t++) step(1'b1, 1'b1, s, a);
        if (!a) check("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int k);
        bit a;
        for (int t = 0; t < k; t++) step(1'b1, 1'b0, 0, a);
    endtask

    initial begin
        bit a;
        reset = 1'b1; bus.clk_en = 1'b0; bus.valid_in = 1'b0; bus.sample_in = '0;
        pending = 1'b0; err_flag = 1'b0; exp_err_pend = 1'b0; rem = 0; exp_resid = 0;

        do_reset(); feed(0); feed(0); feed(65536);   drain(6);
        do_reset(); feed(0); feed(0); feed(-200000); drain(6);
        do_reset(); feed(0); feed(0); feed(49152);   drain(6);
        do_reset(); feed(0); feed(0); feed(-49152);  drain(6);

        // Fold budget exhausted; flag must stay set across later in-range samples.
        do_reset(); feed(0); feed(0); feed(1000000); drain(8);
        feed(2000000); feed(3000000); drain(6);

        do_reset();
        for (int i = 0; i < 10; i++) feed(0);
        drain(4);

        do_reset(); feed(0); feed(0); feed(65536);
        step(1'b1, 1'b0, 0, a);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, a);
        drain(6);

        // Reset while folding: sample discarded and history re-primes.
        do_reset(); feed(0); feed(0); feed(1000000);
        step(1'b1, 1'b0, 0, a); step(1'b1, 1'b0, 0, a);
        do_reset(); feed(0); feed(0); drain(4); feed(65536); drain(6);

        do_reset();
        for (int i = 0; i < 3000; i++)
            step(($urandom % 8) != 0, ($urandom % 4) != 0,
                 longint'($urandom_range(200000)) - 100000, a);
        drain(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usf_diff_fold_n.md
Name: usf_diff_fold_n

Overview:
- Front stage of the higher-order USF reconstruction chain. Sits directly upstream of the anti-difference/rounding stage.
- Takes modulo-folded ADC samples y[k] and forms the N-th order finite difference Δ^N y[k].
- Folds Δ^N y into [-λ, λ) by iterative ±2λ steps.
- Emits the residual difference Δ^N ε_y[k] = M_λ(Δ^N y[k]) − Δ^N y[k], which is always an integer multiple of 2λ.

Parameters:
- WIDTH, 24, sample and output data width, signed fixed point.
- FRACTIONAL_BITS, 16, fractional bits of all data.
- ORDER, 2, difference order N (legal range 1..4).
- LAMBDA, 0.75, modulo threshold λ. Internal constant LAMBDA_Q = round(LAMBDA·2^FRACTIONAL_BITS); TWO_LAMBDA_Q = 2·LAMBDA_Q.
- MAX_FOLD, 15, maximum fold iterations per sample.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clk_en  input  1  clock enable; when 0, all registers hold.
- valid_in  input  1  sample_in valid; a sample is accepted when valid_in & in_ready.
- sample_in  input  WIDTH  folded sample y[k], signed Q(WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS.
- in_ready  output  1  block can accept a sample this cycle.
- valid_out  output  1  one-enabled-cycle pulse; residual_diff_out is valid.
- residual_diff_out  output  WIDTH  Δ^N ε_y[k], signed, same format as sample_in.
- fold_err  output  1  sticky flag: MAX_FOLD exceeded since reset.

Behaviour:
- Clocking and reset
  - Single clock, clk. Reset is synchronous, active-high, and evaluated regardless of clk_en.
  - Reset values: valid_out=0, residual_diff_out=0, fold_err=0, in_ready=0 during reset and 1 on the first cycle after.
  - Reset also clears history registers, prime counter, fold state, and returns the FSM to IDLE.
- clk_en = 0
  - Every register holds, including valid_out and residual_diff_out.
  - in_ready is forced to 0.
- History and priming
  - ORDER-deep history of accepted samples.
  - Δ^N y = cascade of ORDER signed subtractions over {sample_in, history}.
  - Cascade is computed in WIDTH+ORDER bits; no wrap is allowed.
  - Prime counter saturates at ORDER. While the counter < ORDER, an accept only shifts history and increments the counter; no fold and no output occur.
- FSM states
  - IDLE: in_ready = clk_en. On accept with the prime counter at ORDER:
    - register D = Δ^N y and corr = 0, set n = 0;
    - shift history;
    - go to FOLD.
  - FOLD: one evaluation per enabled cycle.
    - If D ≥ LAMBDA_Q: D −= TWO_LAMBDA_Q, corr −= TWO_LAMBDA_Q, n++.
    - Else if D < −LAMBDA_Q: D += TWO_LAMBDA_Q, corr += TWO_LAMBDA_Q, n++.
    - Else: go to OUT.
    - If an adjustment is required and n == MAX_FOLD: set fold_err and go to OUT with the current corr.
  - OUT: residual_diff_out = corr, saturated to WIDTH; valid_out = 1 for this cycle; in_ready = clk_en, so a new accept may occur in the same cycle; next state IDLE, or FOLD on accept.
- Range and arithmetic
  - Fold range is half-open: exactly +λ folds; exactly −λ does not.
  - corr is held in WIDTH+ORDER+1 bits and saturates to ±(2^(WIDTH−1)−1 / −2^(WIDTH−1)) on output.
- Latency and throughput
  - Latency from accept to valid_out = 2 + n enabled cycles (n = folds performed).
  - Throughput: one sample per 2+n enabled cycles.
  - valid_out is 0 in every cycle other than OUT.
- Edge cases
  - Reset mid-FOLD discards the sample, and the next ORDER samples re-prime.
  - valid_in while in_ready = 0 is ignored; upstream must hold the sample.

Test Plan (ORDER=2, LAMBDA=0.75 → LAMBDA_Q=49152, TWO_LAMBDA_Q=98304; reset before each):
- Samples 0,0,65536 → Δ²=65536, one fold to −32768 → residual_diff_out=−98304; valid_out 3 enabled cycles after the third accept; no valid_out for the first two samples.
- Samples 0,0,−200000 → two folds to −3392 → residual_diff_out=+196608; latency 4.
- Samples 0,0,49152 → folds to −49152 → −98304. Samples 0,0,−49152 → residual_diff_out=0 with zero folds, latency 2.
- MAX_FOLD=4, samples 0,0,1000000 → after 4 folds residual_diff_out=−393216 and fold_err=1; fold_err stays 1 across later good samples until reset.
- Continuous valid_in with Δ² in range (samples 0,0,0,0,…) → one output of 0 every 2 cycles; in_ready pattern 1,0,1,0; clk_en toggled low mid-FOLD holds all outputs and extends latency by the number of disabled cycles.
- Reset asserted during FOLD → valid_out=0, fold_err=0 next cycle, in_ready=1 afterwards; the next two samples produce no output (re-prime).
